// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: owns the PC and runs one req/ready instruction fetch at
// a time into IF/ID. It absorbs hazard stalls and branch redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        fetch_valid,
  output logic        if_id_enable
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_buf;
  logic [31:0] r_drain_addr;
  logic [31:0] w_pc_next;

  assign w_pc_next = r_pc + 32'(PC_STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_hold_buf   <= '0;
      r_drain_addr <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (branch_taken) begin
            r_pc <= branch_target;
            if (!imem_ready) begin
              // The old request is still in flight; remember its address so the
              // bus stays stable until its response is swallowed.
              r_drain_addr <= r_pc;
              r_state      <= S_DRAIN;
            end
          end else if (imem_ready && !stall) begin
            r_pc <= w_pc_next;
          end else if (imem_ready) begin
            r_hold_buf <= imem_rdata;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (branch_taken) begin
            r_pc    <= branch_target;
            r_state <= S_FETCH;
          end else if (!stall) begin
            r_pc    <= w_pc_next;
            r_state <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (branch_taken) r_pc <= branch_target;
          if (imem_ready) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = r_pc;
    instr_out   = '0;
    pc_out      = r_pc;
    fetch_valid = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          imem_req    = 1'b1;
          instr_out   = imem_rdata;
          fetch_valid = imem_ready & ~branch_taken;
        end
        S_HOLD: begin
          instr_out   = r_hold_buf;
          fetch_valid = ~branch_taken;
        end
        S_DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = r_drain_addr;
        end
        default: ;
      endcase
    end
  end

  assign if_id_enable = fetch_valid & ~stall;

endmodule
